// File: rtl/sum_uart_tx.sv
// sum_uart_tx
//   Serial output stage for the 8-bit adder. Sums are accepted through a
//   valid/ready handshake into a 2-entry FIFO. They are then sent on one pin
//   as UART 8N1 frames: start bit, 8 data bits LSB first, stop bit. Each bit
//   lasts CLKS_PER_BIT clocks.
//
// Parameters
//   CLKS_PER_BIT  clocks per UART bit (2..65535)
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   sum_in     sum byte from the adder
//   sum_valid  sum_in holds a byte to be sent
//   sum_ready  a byte can be accepted this cycle
//   tx         UART serial output, idle high, registered
//   busy       FIFO non-empty or frame in progress
//
// States
//   state | meaning
//   IDLE  | line high, waiting for a queued byte
//   START | start bit (tx = 0)
//   DATA  | data bits, LSB first, bit_idx 0..7
//   STOP  | stop bit (tx = 1); chains straight into START if a byte is queued

module sum_uart_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] sum_in,
    input  logic       sum_valid,
    output logic       sum_ready,
    output logic       tx,
    output logic       busy
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [7:0]    fifo_mem [2];
    logic          rd_ptr;
    logic          wr_ptr;
    logic [1:0]    count;

    logic [1:0]    state;
    logic [CW-1:0] baud;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;

    logic          push;
    logic          pop;
    logic          baud_done;

    // Ready comes from the registered count only, so a pop never frees a
    // slot for a push in the same cycle.
    assign sum_ready = (count != 2'd2) && rst_n;
    assign push      = sum_valid && sum_ready;
    assign baud_done = (baud == BAUD_LAST);
    assign pop       = (count != 2'd0) &&
                       ((state == S_IDLE) || ((state == S_STOP) && baud_done));
    assign busy      = (state != S_IDLE) || (count != 2'd0);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= sum_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            baud    <= '0;
            bit_idx <= 3'd0;
            shift   <= 8'h00;
            tx      <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    baud <= '0;
                    if (pop) begin
                        state <= S_START;
                        shift <= fifo_mem[rd_ptr];
                        tx    <= 1'b0;
                    end
                end
                S_START: begin
                    if (baud_done) begin
                        state   <= S_DATA;
                        baud    <= '0;
                        bit_idx <= 3'd0;
                        tx      <= shift[0];
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                S_DATA: begin
                    if (baud_done) begin
                        baud <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                            tx    <= 1'b1;
                        end else begin
                            // shift[0] is the bit being sent; shift[1] is next.
                            bit_idx <= bit_idx + 3'd1;
                            shift   <= {1'b0, shift[7:1]};
                            tx      <= shift[1];
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                S_STOP: begin
                    if (baud_done) begin
                        baud <= '0;
                        if (pop) begin
                            state <= S_START;
                            shift <= fifo_mem[rd_ptr];
                            tx    <= 1'b0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    baud  <= '0;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sum_uart_tx.sv
// tb_sum_uart_tx
//   Self-checking bench for sum_uart_tx. Two instances are used: one with
//   CLKS_PER_BIT = 4 and one with the minimum divider of 2. Both instances
//   share the same stimulus, and sel picks which one is checked. The
//   reference model keeps, for every accepted byte, the edge it was
//   accepted on and the edge its frame starts. The expected tx, busy and
//   sum_ready levels on any cycle are computed from those times by plain
//   arithmetic.

module tb_sum_uart_tx;

    logic       clk;
    logic       rst_n;
    logic       sum_valid;
    logic [7:0] sum_in;
    logic       ready_a, tx_a, busy_a;
    logic       ready_b, tx_b, busy_b;

    logic       sel;
    int         cpb;
    int         cyc;
    int         n_checks;
    int         n_fail;
    logic       acc_dummy;

    int         acc_q[$];
    int         st_q[$];
    logic [7:0] by_q[$];

    logic tx_m, busy_m, ready_m;
    assign tx_m    = sel ? tx_b    : tx_a;
    assign busy_m  = sel ? busy_b  : busy_a;
    assign ready_m = sel ? ready_b : ready_a;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;   // bit 0 = start bit level, bit 9 = stop bit level
    } vec_t;
    vec_t tbl[5];

    sum_uart_tx #(.CLKS_PER_BIT(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .sum_in(sum_in), .sum_valid(sum_valid),
        .sum_ready(ready_a), .tx(tx_a), .busy(busy_a)
    );

    sum_uart_tx #(.CLKS_PER_BIT(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .sum_in(sum_in), .sum_valid(sum_valid),
        .sum_ready(ready_b), .tx(tx_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    function automatic void mdl_clear();
        acc_q.delete();
        st_q.delete();
        by_q.delete();
    endfunction

    // A frame starts one edge after acceptance, or as soon as the previous
    // frame's 10 bit times are over, whichever is later.
    function automatic void mdl_accept(input int e, input logic [7:0] d);
        int s;
        s = e + 1;
        if (st_q.size() > 0 && st_q[st_q.size()-1] + 10*cpb > s)
            s = st_q[st_q.size()-1] + 10*cpb;
        acc_q.push_back(e);
        st_q.push_back(s);
        by_q.push_back(d);
    endfunction

    function automatic logic mdl_tx(input int c);
        int o;
        int b;
        foreach (st_q[i]) begin
            if (c >= st_q[i] && c < st_q[i] + 10*cpb) begin
                o = c - st_q[i];
                b = o / cpb;
                if (b == 0) return 1'b0;
                if (b == 9) return 1'b1;
                return by_q[i][b-1];
            end
        end
        return 1'b1;
    endfunction

    function automatic logic mdl_busy(input int c);
        foreach (acc_q[i])
            if (acc_q[i] <= c && c < st_q[i] + 10*cpb) return 1'b1;
        return 1'b0;
    endfunction

    // Bytes held in the FIFO after edge c: accepted so far minus started so far.
    function automatic logic mdl_ready(input int c);
        int cnt;
        cnt = 0;
        foreach (acc_q[i]) begin
            if (acc_q[i] <= c) cnt++;
            if (st_q[i] <= c) cnt--;
        end
        return (cnt < 2);
    endfunction

    task automatic check_now();
        if (!rst_n) begin
            chk("rst_tx", tx_m, 1'b1);
            chk("rst_busy", busy_m, 1'b0);
            chk("rst_ready", ready_m, 1'b0);
        end else begin
            chk("mdl_tx", tx_m, mdl_tx(cyc));
            chk("mdl_busy", busy_m, mdl_busy(cyc));
            chk("mdl_ready", ready_m, mdl_ready(cyc));
        end
    endtask

    // Called at a negedge: drive inputs for the next edge, advance one cycle,
    // then check outputs at the following negedge.
    task automatic step(input logic v, input logic [7:0] d, output logic acc);
        sum_valid = v;
        sum_in    = d;
        acc       = 1'b0;
        if (v && rst_n && mdl_ready(cyc)) begin
            mdl_accept(cyc + 1, d);
            acc = 1'b1;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check_now();
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (mdl_busy(cyc) && t < 2000) begin
            step(1'b0, 8'h00, acc_dummy);
            t++;
        end
        if (mdl_busy(cyc)) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout at cycle %0d: still busy after %0d cycles", cyc, t);
        end
        repeat (3) step(1'b0, 8'h00, acc_dummy);
        mdl_clear();
    endtask

    task automatic do_reset(input logic new_sel, input int new_cpb);
        rst_n = 1'b0;
        sel   = new_sel;
        cpb   = new_cpb;
        mdl_clear();
        repeat (2) step(1'b0, 8'h00, acc_dummy);
        rst_n = 1'b1;
        step(1'b0, 8'h00, acc_dummy);
    endtask

    initial begin
        int k;
        int o;
        int idx;
        logic a;
        logic [7:0] bp [3];

        tbl[0] = '{8'hA5, 10'b1_10100101_0};
        tbl[1] = '{8'h00, 10'b1_00000000_0};
        tbl[2] = '{8'hFF, 10'b1_11111111_0};
        tbl[3] = '{8'h3C, 10'b1_00111100_0};
        tbl[4] = '{8'h81, 10'b1_10000001_0};
        bp[0] = 8'h01; bp[1] = 8'h02; bp[2] = 8'h03;

        n_checks  = 0;
        n_fail    = 0;
        cyc       = 0;
        sel       = 1'b0;
        cpb       = 4;
        sum_valid = 1'b0;
        sum_in    = 8'h00;
        rst_n     = 1'b1;
        #2 rst_n  = 1'b0;

        // Reset held 5 cycles, then released.
        @(negedge clk);
        repeat (5) step(1'b0, 8'h00, acc_dummy);
        rst_n = 1'b1;
        step(1'b0, 8'h00, acc_dummy);
        chk("ready_after_reset", ready_m, 1'b1);

        // Table: single frames, mid-bit sampling plus busy fall at k+1+10*cpb.
        foreach (tbl[i]) begin
            k = cyc + 1;
            step(1'b1, tbl[i].data, acc_dummy);
            for (int t = 1; t <= 10*cpb + 1; t++) begin
                step(1'b0, 8'h00, acc_dummy);
                o = cyc - (k + 1);
                if (o >= 0 && o < 10*cpb && (o % cpb) == cpb/2)
                    chk("tbl_bit", tx_m, tbl[i].frame[o/cpb]);
                if (cyc == k + 10*cpb)
                    chk("tbl_busy_last", busy_m, 1'b1);
            end
            chk("tbl_busy_end", busy_m, 1'b0);
            drain();
        end

        // Back-to-back with back-pressure.
        idx = 0;
        for (int t = 0; t < 200 && idx < 3; t++) begin
            step(1'b1, bp[idx], a);
            if (a) idx++;
        end
        chk("bp_ready_low", ready_m, 1'b0);
        while (st_q.size() > 1 && cyc < st_q[1] - 1) step(1'b0, 8'h00, acc_dummy);
        chk("bp_ready_still_low", ready_m, 1'b0);
        step(1'b0, 8'h00, acc_dummy);
        chk("bp_ready_back", ready_m, 1'b1);
        chk("bp_no_gap", tx_m, 1'b0);
        drain();

        // Simultaneous push and pop at the STOP->START edge with count = 1.
        step(1'b1, 8'h11, acc_dummy);
        step(1'b1, 8'h22, acc_dummy);
        while (cyc < st_q[0] + 10*cpb - 1) step(1'b0, 8'h00, acc_dummy);
        step(1'b1, 8'h7E, acc_dummy);
        chk("pp_ready_count1", ready_m, 1'b1);
        chk("pp_start_bit", tx_m, 1'b0);
        drain();

        // Reset during data bit 3 of 0xFF with one byte queued.
        step(1'b1, 8'hFF, acc_dummy);
        step(1'b1, 8'h5A, acc_dummy);
        while (cyc < st_q[0] + 4*cpb + 1) step(1'b0, 8'h00, acc_dummy);
        chk("pre_rst_busy", busy_m, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_tx", tx_m, 1'b1);
        chk("async_rst_busy", busy_m, 1'b0);
        chk("async_rst_ready", ready_m, 1'b0);
        mdl_clear();
        @(negedge clk);
        repeat (3) step(1'b0, 8'h00, acc_dummy);
        rst_n = 1'b1;
        repeat (50) step(1'b0, 8'h00, acc_dummy);
        chk("rst_no_frame_busy", busy_m, 1'b0);
        step(1'b1, 8'h3C, acc_dummy);
        drain();

        // Random traffic on CLKS_PER_BIT = 4.
        for (int t = 0; t < 1500; t++)
            step($urandom_range(0, 2) == 0, 8'($urandom), acc_dummy);
        drain();

        // Minimum divider.
        do_reset(1'b1, 2);
        k = cyc + 1;
        step(1'b1, 8'h00, acc_dummy);
        step(1'b1, 8'hFF, acc_dummy);
        while (cyc < k + 1 + 17) step(1'b0, 8'h00, acc_dummy);
        chk("min_bit7_low", tx_m, 1'b0);
        step(1'b0, 8'h00, acc_dummy);
        chk("min_stop_0", tx_m, 1'b1);
        step(1'b0, 8'h00, acc_dummy);
        chk("min_stop_1", tx_m, 1'b1);
        step(1'b0, 8'h00, acc_dummy);
        chk("min_next_start", tx_m, 1'b0);
        while (cyc < k + 1 + 20 + 19) step(1'b0, 8'h00, acc_dummy);
        chk("min_ff_stop", tx_m, 1'b1);
        drain();

        for (int t = 0; t < 800; t++)
            step($urandom_range(0, 1) == 0, 8'($urandom), acc_dummy);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
